// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I OP/OP-IMM issue controller: decode, regfile read, ALU drive, writeback
module alu_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] alu_operand1,
    output logic [XLEN-1:0] alu_operand2,
    output logic [2:0]      alu_func3,
    output logic            alu_subsra,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {IDLE, DEC, EXE, WB} state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NREGS];

    logic            dec_legal;
    logic            dec_subsra;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;

    logic [6:0] opcode;
    logic [4:0] rd_idx;
    logic [2:0] f3;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [6:0] f7;

    assign opcode  = ir[6:0];
    assign rd_idx  = ir[11:7];
    assign f3      = ir[14:12];
    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign f7      = ir[31:25];

    // x0 and indices beyond the implemented file read as zero
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || 32'(idx) >= NREGS)
            return '0;
        return regs[idx[AW-1:0]];
    endfunction

    function automatic logic idx_bad(input logic [4:0] idx);
        return 32'(idx) >= NREGS;
    endfunction

    assign instr_ready = (state == IDLE);
    assign dbg_data    = rf_read(dbg_addr);

    // Decode the latched word into legality, shift/sub selector and operands
    always_comb begin
        dec_legal  = 1'b0;
        dec_subsra = 1'b0;
        dec_op1    = rf_read(rs1_idx);
        dec_op2    = rf_read(rs2_idx);
        if (opcode == OPC_OP) begin
            if (f7 == F7_ZERO) begin
                dec_legal = 1'b1;
            end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                dec_legal  = 1'b1;
                dec_subsra = 1'b1;
            end
            if (idx_bad(rs2_idx))
                dec_legal = 1'b0;
        end else if (opcode == OPC_OP_IMM) begin
            dec_op2 = {{(XLEN-12){ir[31]}}, ir[31:20]};
            case (f3)
                3'b001: dec_legal = (f7 == F7_ZERO);
                3'b101: begin
                    if (f7 == F7_ZERO) begin
                        dec_legal = 1'b1;
                    end else if (f7 == F7_ALT) begin
                        dec_legal  = 1'b1;
                        dec_subsra = 1'b1;
                    end
                end
                default: dec_legal = 1'b1;
            endcase
        end
        if (idx_bad(rd_idx) || idx_bad(rs1_idx))
            dec_legal = 1'b0;
    end

    // Issue FSM: one instruction in flight through DEC, EXE and WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ir           <= '0;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_func3    <= '0;
            alu_subsra   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            illegal      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= DEC;
                    end
                end
                DEC: begin
                    if (dec_legal) begin
                        alu_operand1 <= dec_op1;
                        alu_operand2 <= dec_op2;
                        alu_func3    <= f3;
                        alu_subsra   <= dec_subsra;
                        state        <= EXE;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXE: begin
                    wb_data  <= alu_result;
                    wb_rd    <= rd_idx;
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file: commit the captured result at the end of WB; x0 never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (state == WB && wb_rd != 5'd0 && !idx_bad(wb_rd)) begin
            regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] alu_operand1;
    logic [31:0] alu_operand2;
    logic [2:0]  alu_func3;
    logic        alu_subsra;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    alu_issue_ctrl #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_func3(alu_func3), .alu_subsra(alu_subsra), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // RV32I ALU behaviour
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f, input logic s);
        case (f)
            3'd0: return s ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_operand1, alu_operand2, alu_func3, alu_subsra);

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] mregs [32];

    logic        obs_illegal;
    logic        obs_sub;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode straight from the ISA rules for OP / OP-IMM
    function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                       output logic [31:0] a, output logic [31:0] b,
                                       output logic [2:0] f, output bit s);
        logic [6:0] f7;
        f7 = w[31:25];
        f  = w[14:12];
        a  = mregs[w[19:15]];
        b  = 32'd0;
        s  = 0;
        legal = 0;
        if (w[6:0] == 7'h33) begin
            b = mregs[w[24:20]];
            s = (f7 == 7'h20);
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f == 3'd0 || f == 3'd5));
        end else if (w[6:0] == 7'h13) begin
            b = {{20{w[31]}}, w[31:20]};
            if (f == 3'd1) legal = (f7 == 7'h00);
            else if (f == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
            else legal = 1;
            s = (f == 3'd5 && f7 == 7'h20);
        end
    endfunction

    task automatic run_instr(input logic [31:0] w);
        bit legal, s;
        logic [31:0] a, b, res, p1, p2;
        logic [2:0] f, pf;
        logic ps;
        int k;
        ref_decode(w, legal, a, b, f, s);
        res = alu_ref(a, b, f, s);
        p1 = alu_operand1; p2 = alu_operand2; pf = alu_func3; ps = alu_subsra;
        k = 0;
        while (!instr_ready && k < 20) begin tick(); k++; end
        if (!instr_ready) chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr = w;
        tick();
        instr_valid = 1'b0;
        instr = $urandom;
        chk("dec_ready_low", {31'd0, instr_ready}, 32'd0);
        tick();
        obs_illegal = illegal;
        obs_sub = alu_subsra;
        if (legal) begin
            chk("op1", alu_operand1, a);
            chk("op2", alu_operand2, b);
            chk("func3", {29'd0, alu_func3}, {29'd0, f});
            chk("subsra", {31'd0, alu_subsra}, {31'd0, s});
            chk("no_illegal", {31'd0, illegal}, 32'd0);
            chk("exe_no_wb", {31'd0, wb_valid}, 32'd0);
            tick();
            obs_rd = wb_rd;
            obs_data = wb_data;
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, w[11:7]});
            chk("wb_data", wb_data, res);
            chk("wb_ready_low", {31'd0, instr_ready}, 32'd0);
            tick();
            if (w[11:7] != 5'd0) mregs[w[11:7]] = res;
            chk("wb_pulse_end", {31'd0, wb_valid}, 32'd0);
            chk("ready_back", {31'd0, instr_ready}, 32'd1);
            dbg_addr = w[11:7];
            #1;
            chk("dbg_rd", dbg_data, mregs[w[11:7]]);
        end else begin
            chk("illegal_pulse", {31'd0, illegal}, 32'd1);
            chk("illegal_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("illegal_hold_op1", alu_operand1, p1);
            chk("illegal_hold_op2", alu_operand2, p2);
            chk("illegal_hold_ctl", {28'd0, alu_subsra, alu_func3}, {28'd0, ps, pf});
            chk("illegal_ready", {31'd0, instr_ready}, 32'd1);
            tick();
            chk("illegal_end", {31'd0, illegal | wb_valid}, 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] word;
        bit          legal;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          sub;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [31:0] rand_f7();
        int p;
        p = $urandom_range(0, 3);
        if (p < 2) return 32'h00;
        if (p == 2) return 32'h20;
        return 32'($urandom_range(0, 127));
    endfunction

    initial begin
        logic [31:0] w;
        logic [31:0] f7r;
        int r;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

        tbl[0] = '{32'h01000093, 1, 5'd1, 32'h00000010, 0};
        tbl[1] = '{32'h00500113, 1, 5'd2, 32'h00000005, 0};
        tbl[2] = '{32'h402081B3, 1, 5'd3, 32'h0000000B, 1};
        tbl[3] = '{32'h80000213, 1, 5'd4, 32'hFFFFF800, 0};
        tbl[4] = '{32'h40425293, 1, 5'd5, 32'hFFFFFF80, 1};
        tbl[5] = '{32'h0000006F, 0, 5'd0, 32'h0, 0};
        tbl[6] = '{32'h40109313, 0, 5'd0, 32'h0, 0};
        tbl[7] = '{32'h00700013, 1, 5'd0, 32'h00000007, 0};

        // reset state
        #2;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_outs", {alu_operand1 | alu_operand2 | wb_data},
            32'd0);
        chk("rst_flags", {26'd0, alu_func3, alu_subsra, wb_valid, illegal}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // directed vectors
        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].word);
            chk($sformatf("tbl%0d_illegal", i), {31'd0, obs_illegal}, {31'd0, !tbl[i].legal});
            if (tbl[i].legal) begin
                chk($sformatf("tbl%0d_rd", i), {27'd0, obs_rd}, {27'd0, tbl[i].rd});
                chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].data);
                chk($sformatf("tbl%0d_sub", i), {31'd0, obs_sub}, {31'd0, tbl[i].sub});
            end
        end
        dbg_addr = 5'd0; #1; chk("dbg_x0", dbg_data, 32'd0);
        dbg_addr = 5'd1; #1; chk("dbg_x1", dbg_data, 32'h10);
        dbg_addr = 5'd3; #1; chk("dbg_x3", dbg_data, 32'hB);
        dbg_addr = 5'd4; #1; chk("dbg_x4", dbg_data, 32'hFFFFF800);
        dbg_addr = 5'd5; #1; chk("dbg_x5", dbg_data, 32'hFFFFFF80);
        dbg_addr = 5'd6; #1; chk("dbg_x6_unchanged", dbg_data, 32'd0);

        // reset during EXE with instr_valid held high
        instr_valid = 1'b1;
        instr = 32'h00900393;
        tick();
        tick();
        chk("pre_rst_exe_op2", alu_operand2, 32'd9);
        rst = 1'b1;
        #1;
        chk("mid_rst_ops", alu_operand1 | alu_operand2, 32'd0);
        chk("mid_rst_flags", {26'd0, alu_func3, alu_subsra, wb_valid, illegal}, 32'd0);
        dbg_addr = 5'd1; #1; chk("mid_rst_regs", dbg_data, 32'd0);
        tick();
        chk("rst_hold_no_wb", {31'd0, wb_valid}, 32'd0);
        tick();
        rst = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        tick();
        chk("post_rst_no_wb", {31'd0, wb_valid}, 32'd0);

        // randomized instructions against the reference model
        for (int n = 0; n < 200; n++) begin
            w = $urandom;
            r = $urandom_range(0, 9);
            f7r = rand_f7();
            if (r < 4) begin
                w[6:0] = 7'h33;
                w[31:25] = f7r[6:0];
            end else if (r < 9) begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = f7r[6:0];
            end
            run_instr(w);
        end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk($sformatf("final_x%0d", i), dbg_data, mregs[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
